seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
- Display controller for the 4-digit common-anode seven-segment display.
- Accepts an 8-bit value and a display mode, and converts it to three decimal digits with a sequential double-dabble engine, or splits it into two hex nibbles.
- Time-multiplexes the digits onto one shared instance of the hex-to-segment decoder, seven_seg, with active-low segments and anodes.
- Sits between the computer's output register and the board display pins.

Parameters:
- SCAN_DIV, 50000: clocks each digit is lit before the scan advances; must be ≥1. The prescaler width is $clog2(SCAN_DIV)+1.
- NUM_DIGITS, 4: anode count. Fixed at 4; not a supported override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  8  unsigned value to display
- hex_mode  in  1  0 = decimal (3 digits), 1 = hex (2 digits); sampled with load
- load  in  1  single-cycle request to capture value/hex_mode
- busy  out  1  conversion in progress; load is ignored while high
- seg  out  7  active-low segments {g,f,e,d,c,b,a}, registered
- an  out  4  active-low anode enables, one-hot-low, registered

Behaviour:
- Reset (async assert, sync release) sets:
  - seg=7'b1111111, an=4'b1111, busy=0
  - digit registers d2/d1/d0=0, display mode=decimal, prescaler=0, scan index=0
  - FSM=IDLE
- FSM states IDLE, SHIFT, COMMIT.
  - IDLE + load + hex_mode=1: d1=value[7:4], d0=value[3:0], d2 blank, mode=hex. Registers update at edge N+1; busy stays 0; FSM stays IDLE.
  - IDLE + load + hex_mode=0: capture value into the shift register, clear BCD, iteration counter=0, busy=1 at N+1, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble ≥5, then shift left one bit. After 8 iterations, go to COMMIT.
  - COMMIT: copy the BCD nibbles to d2/d1/d0, set mode=decimal, busy=0, go to IDLE. Decimal latency: digits visible in the registers at N+9, busy high for cycles N+1..N+8.
- load while busy: ignored, with no queuing. load in the same cycle as COMMIT: ignored.
- The display registers keep the previous value throughout a conversion, so the display never shows a partial result.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps. On the wrap, the scan index steps 0→1→2→3→0.
  - Each cycle, an <= ~(4'b0001<<idx) and seg <= the segment pattern for digit idx. Outputs lag the index by one cycle.
  - Digit 3 is always blank (7'b1111111). Digit 2 is blank in hex mode.
  - With SCAN_DIV=1 the index advances every cycle.
- Reset mid-conversion: aborts the conversion and clears the digits to 0. No stale result is committed.

Optional Feature:
- SEVSEG_LZ_BLANK_EN defined: leading-zero blanking.
  - Decimal: d2 blank if 0; d1 blank if d2 and d1 are both 0.
  - Hex: d1 blank if 0.
  - d0 is never blanked.
- Undefined: all active digits show, including zeros. Blanking affects seg only; the an sequence is unchanged.

Decomposition:
- Package seven_seg_pkg:
  - SEG_BLANK=7'b1111111
  - NUM_DIGITS
  - state enum {IDLE,SHIFT,COMMIT}
  - BCD_ITER=8
- Sub-module bin2bcd_seq: the start/busy/done double-dabble engine, 8-bit in, 12-bit BCD out.
- Digit decode reuses a single seven_seg instance.

Test Plan:
- Reset: rst_n=0 mid-scan → seg=7'h7F, an=4'hF immediately. First edge after release → an=4'b1110, seg=7'b1000000.
- load value=8'd255, hex_mode=0 at N → busy=1 during N+1..N+8. At N+9: d2 seg 7'b0100100, d1/d0 seg 7'b0010010.
- load value=8'hA7, hex_mode=1 → at N+1, d1 seg 7'b0001000, d0 seg 7'b1111000, d2/d3 seg 7'h7F. busy never high.
- Conversion 8'd12 running; load 8'd99 at N+3 → 8'd99 ignored; final digits read 0,1,2.
- SCAN_DIV=4 → an steps 1110→1101→1011→0111→1110, each held 4 cycles.
- Load 8'd7 decimal → with SEVSEG_LZ_BLANK_EN, d2/d1 seg 7'h7F. Without it, both 7'b1000000. d0 is 7'b1111000 either way.
- rst_n pulse at N+4 of a decimal conversion of 8'd200 → digits 0,0,0 and busy=0 after release; no later commit.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM encoding and BCD helper for the seven-segment scan controller.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam int         NUM_DIGITS = 4;
  localparam int         BCD_ITER   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  // Double-dabble correction: any BCD nibble of 5 or more gets 3 added before the shift.
  function automatic logic [11:0] bcd_adj(input logic [11:0] b);
    logic [3:0] nib;
    bcd_adj = b;
    for (int i = 0; i < 3; i++) begin
      nib = b[i*4 +: 4];
      if (nib >= 4'd5) bcd_adj[i*4 +: 4] = nib + 4'd3;
    end
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble engine: 8-bit binary in, three BCD nibbles out.
module bin2bcd_seq
  import seven_seg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [11:0] o_bcd
);

  localparam logic [3:0] ITER_LAST = 4'(BCD_ITER - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_sr;
  logic [11:0] r_bcd;
  logic [3:0]  r_iter;
  logic [11:0] w_adj;

  assign w_adj  = bcd_adj(r_bcd);
  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == COMMIT);
  assign o_bcd  = r_bcd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = SHIFT;
      SHIFT:   if (r_iter == ITER_LAST) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The capture edge already performs the first iteration: the BCD is zero there,
  // so the add-3 step is a no-op and only the shift remains. This keeps the whole
  // conversion to 8 busy cycles including the commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr   <= '0;
      r_bcd  <= '0;
      r_iter <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_sr   <= {i_bin[6:0], 1'b0};
      r_bcd  <= {11'b0, i_bin[7]};
      r_iter <= 4'd1;
    end else if (r_state == SHIFT) begin
      {r_bcd, r_sr} <= {w_adj[10:0], r_sr, 1'b0};
      r_iter        <= r_iter + 4'd1;
    end
  end

endmodule

// File: rtl/seven_seg.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module seven_seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller (decimal via double-dabble, or hex).
// Optional leading-zero blanking when SEVSEG_LZ_BLANK_EN is defined.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       hex_mode,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int PW = $clog2(SCAN_DIV) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [3:0]    r_d2, r_d1, r_d0;
  logic          r_hex;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_busy;
  logic          w_done;
  logic          w_start;
  logic [11:0]   w_bcd;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [6:0]    w_dec_seg;
  logic          w_lz_d2;
  logic          w_lz_d1;

  assign w_start = load && !hex_mode && !w_busy;
  assign busy    = w_busy;
  assign seg     = r_seg;
  assign an      = r_an;

  bin2bcd_seq u_bcd (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (w_start),
    .i_bin   (value),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Display registers change only on a hex load or a finished conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d2  <= '0;
      r_d1  <= '0;
      r_d0  <= '0;
      r_hex <= 1'b0;
    end else if (w_done) begin
      r_d2  <= w_bcd[11:8];
      r_d1  <= w_bcd[7:4];
      r_d0  <= w_bcd[3:0];
      r_hex <= 1'b0;
    end else if (load && hex_mode && !w_busy) begin
      r_d2  <= '0;
      r_d1  <= value[7:4];
      r_d0  <= value[3:0];
      r_hex <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

`ifdef SEVSEG_LZ_BLANK_EN
  assign w_lz_d2 = (r_d2 == 4'd0);
  assign w_lz_d1 = r_hex ? (r_d1 == 4'd0) : ((r_d2 == 4'd0) && (r_d1 == 4'd0));
`else
  assign w_lz_d2 = 1'b0;
  assign w_lz_d1 = 1'b0;
`endif

  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b1;
    case (r_idx)
      2'd0: begin w_nib = r_d0; w_blank = 1'b0;              end
      2'd1: begin w_nib = r_d1; w_blank = w_lz_d1;           end
      2'd2: begin w_nib = r_d2; w_blank = r_hex || w_lz_d2;  end
      default: begin w_nib = 4'd0; w_blank = 1'b1;           end
    endcase
  end

  seven_seg u_dec (
    .i_hex (w_nib),
    .o_seg (w_dec_seg)
  );

  // Output stage: segments and anodes trail the scan index by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
      r_an  <= ~(4'b0001 << r_idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with SCAN_DIV=4; honours SEVSEG_LZ_BLANK_EN.
module tb_seven_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] value;
  logic       hex_mode;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

`ifdef SEVSEG_LZ_BLANK_EN
  localparam logic [6:0] ZLEAD = 7'h7F;
`else
  localparam logic [6:0] ZLEAD = 7'b1000000;
`endif
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'h7F;

  seven_seg_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .hex_mode (hex_mode),
    .load     (load),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_digit(input string tag, input int k, input logic [6:0] exp);
    logic [3:0] mask;
    logic       found;
    found = 1'b0;
    mask  = ~(4'b0001 << k);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an === mask) begin
        found = 1'b1;
        break;
      end
    end
    if (found) chk(tag, {1'b0, seg}, {1'b0, exp});
    else begin
      checks++;
      errors++;
      $error("FAIL %s observed=no_anode expected=an_%h", tag, mask);
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    repeat (2) @(negedge clk);
    read_digit({tag, "_d0"}, 0, e0);
    read_digit({tag, "_d1"}, 1, e1);
    read_digit({tag, "_d2"}, 2, e2);
    read_digit({tag, "_d3"}, 3, e3);
  endtask

  task automatic do_load(input logic [7:0] v, input logic hm);
    @(negedge clk);
    value    = v;
    hex_mode = hm;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [6:0] scan_seg [4];
    int idx;
    scan_seg[0] = S0; scan_seg[1] = ZLEAD; scan_seg[2] = ZLEAD; scan_seg[3] = SB;

    rst_n = 1'b0; value = 8'd0; hex_mode = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_an", {4'b0, an}, 8'h0F);
    chk("rst_busy", {7'b0, busy}, 8'h00);

    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_an", {4'b0, an}, 8'h0E);
    chk("rel_seg", {1'b0, seg}, {1'b0, S0});

    // edge k after release shows index ((k-1)/4)%4
    for (int k = 2; k <= 18; k++) begin
      @(negedge clk);
      idx     = ((k - 1) / 4) % 4;
      exp_an  = ~(4'b0001 << idx);
      exp_seg = scan_seg[idx];
      chk($sformatf("scan_an_%0d", k), {4'b0, an}, {4'b0, exp_an});
      chk($sformatf("scan_seg_%0d", k), {1'b0, seg}, {1'b0, exp_seg});
    end

    do_load(8'd255, 1'b0);
    chk("d255_busy_1", {7'b0, busy}, 8'h01);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("d255_busy_%0d", c), {7'b0, busy}, 8'h01);
    end
    @(negedge clk);
    chk("d255_busy_9", {7'b0, busy}, 8'h00);
    check_digits("d255", S5, S5, S2, SB);

    do_load(8'hA7, 1'b1);
    chk("hA7_busy_1", {7'b0, busy}, 8'h00);
    @(negedge clk);
    chk("hA7_busy_2", {7'b0, busy}, 8'h00);
    check_digits("hA7", S7, SA, SB, SB);

    do_load(8'd12, 1'b0);
    @(negedge clk);
    value = 8'd99; hex_mode = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("d12_busy_mid", {7'b0, busy}, 8'h01);
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    chk("d12_done", {7'b0, busy}, 8'h00);
    repeat (3) @(negedge clk);
    chk("d99_not_queued", {7'b0, busy}, 8'h00);
    check_digits("d12", S2, S1, ZLEAD, SB);

    do_load(8'd7, 1'b0);
    repeat (9) @(negedge clk);
    check_digits("d7", S7, ZLEAD, ZLEAD, SB);

    do_load(8'd200, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_an", {4'b0, an}, 8'h0F);
    chk("mid_rst_busy", {7'b0, busy}, 8'h00);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("abort_busy_%0d", c), {7'b0, busy}, 8'h00);
    end
    check_digits("abort", S0, ZLEAD, ZLEAD, SB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
